// File: rtl/spi_capture.sv
// SPI mode-0 bus monitor: MSB-first byte capture into a FWFT FIFO; SPI_CAPTURE_FRAME_MARK_EN appends 0x0A after non-empty frames.
// Latency <= 4 clk from 8th spi_clk edge to rxValid; rxReady backpressure holds rxData, bytes arriving at a full FIFO are dropped (sticky overflow).

module spi_capture_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign rd_vld = (count != '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_rdy = (count != FULL_CNT) || rd_rdy;
  assign wr_en  = wr_vld && wr_rdy;
  assign rd_en  = rd_vld && rd_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end
endmodule

module spi_capture #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_do,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic [7:0] byteCnt,
  output logic       overflow,
  output logic       busy
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  logic       cs_s1, cs_s2, cs_s3;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       do_s1, do_s2;
  logic       cs_fall, cs_rise, sclk_rise;
  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       push_vld;
  logic [7:0] push_dat;
  logic       push_rdy;
`ifdef SPI_CAPTURE_FRAME_MARK_EN
  logic       got_byte;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      do_s1   <= 1'b0;
      do_s2   <= 1'b0;
    end else begin
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      do_s1   <= spi_do;
      do_s2   <= do_s1;
    end
  end

  // do_s2 is the data sample taken together with the sclk_s2 sample that reveals the edge.
  assign cs_fall   = cs_s3 & ~cs_s2;
  assign cs_rise   = ~cs_s3 & cs_s2;
  assign sclk_rise = sclk_s2 & ~sclk_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      push_vld <= 1'b0;
      push_dat <= 8'h00;
`ifdef SPI_CAPTURE_FRAME_MARK_EN
      got_byte <= 1'b0;
`endif
    end else begin
      push_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            busy    <= 1'b1;
            bit_cnt <= 3'd0;
            shreg   <= 7'd0;
`ifdef SPI_CAPTURE_FRAME_MARK_EN
            got_byte <= 1'b0;
`endif
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Any partial byte is simply abandoned here.
            state <= IDLE;
            busy  <= 1'b0;
`ifdef SPI_CAPTURE_FRAME_MARK_EN
            if (got_byte) begin
              push_vld <= 1'b1;
              push_dat <= 8'h0A;
            end
`endif
          end else if (sclk_rise) begin
            shreg   <= {shreg[5:0], do_s2};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              push_vld <= 1'b1;
              push_dat <= {shreg, do_s2};
`ifdef SPI_CAPTURE_FRAME_MARK_EN
              got_byte <= 1'b1;
`endif
            end
          end
        end
      endcase
    end
  end

  spi_capture_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .wr_rdy (push_rdy),
    .rd_vld (rxValid),
    .rd_dat (rxData),
    .rd_rdy (rxReady)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byteCnt  <= 8'd0;
      overflow <= 1'b0;
    end else if (push_vld) begin
      if (push_rdy) byteCnt <= byteCnt + 8'd1;
      else          overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_capture.sv
// Bench for spi_capture: directed scenarios plus random frames, checked against a byte-queue model.
module tb_spi_capture;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_do = 1'b0;
  logic       rxReady = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic [7:0] byteCnt;
  logic       overflow;
  logic       busy;

  spi_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_do(spi_do),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .byteCnt(byteCnt), .overflow(overflow), .busy(busy)
  );

  always #3 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [7:0] tx[$];
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_ovf = 1'b0;
  int         delivered = 0;
  int         frame_bytes = 0;
  bit         rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a completed byte is kept if the FIFO has room, else it is lost and overflow sticks.
  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) begin
      q.push_back(b);
      exp_cnt = exp_cnt + 8'd1;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (rst && rxValid && rxReady) begin
      if (q.size() == 0) begin
        checks++;
        assert (0) else begin
          errors++;
          $error("FAIL extra_byte: observed %0h expected no byte", rxData);
        end
      end else begin
        check("rx_data", 32'(rxData), 32'(q.pop_front()));
      end
      delivered++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rxReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #(6 * 90000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic send_bits(input logic [7:0] v, input int n, input int half);
    bit was_empty;
    bit seen;
    for (int i = 7; i >= 8 - n; i--) begin
      spi_do = v[i];
      cyc(half);
      spi_clk = 1'b1;
      if (i == 0) begin
        was_empty = (q.size() == 0) && !rxValid;
        model_push(v);
        frame_bytes++;
        if (was_empty) begin
          seen = 1'b0;
          for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (rxValid) seen = 1'b1;
          end
          check("latency", 32'(seen), 32'd1);
          cyc(half - 4);
        end else begin
          cyc(half);
        end
      end else begin
        cyc(half);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    frame_bytes = 0;
    cyc(4);
    check("busy_active", 32'(busy), 32'd1);
  endtask

  task automatic cs_end();
    cyc(4);
    spi_cs = 1'b1;
`ifdef SPI_CAPTURE_FRAME_MARK_EN
    if (frame_bytes > 0) model_push(8'h0A);
`endif
    cyc(6);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic frame(input int half);
    cs_start();
    foreach (tx[i]) send_bits(tx[i], 8, half);
    cs_end();
  endtask

  task automatic drain();
    int n;
    rxReady = 1'b1;
    n = 0;
    while ((q.size() != 0 || rxValid) && n < 400) begin
      cyc(1);
      n++;
    end
    check("drain_done", 32'(q.size() == 0 && !rxValid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(rxValid), 32'd0);
    check("rst_data", 32'(rxData), 32'd0);
    check("rst_cnt", 32'(byteCnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    q.delete();
    exp_cnt = 8'd0;
    exp_ovf = 1'b0;
    spi_cs = 1'b1;
    spi_clk = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(3);
  endtask

  initial begin
    int d0;
    int half;
    #1;
    do_reset();

    // Single byte, ready downstream.
    rxReady = 1'b1;
    tx = '{8'hA5};
    d0 = delivered;
    frame(4);
    drain();
    check("a5_cnt", 32'(byteCnt), 32'(exp_cnt));
`ifdef SPI_CAPTURE_FRAME_MARK_EN
    check("a5_delivered", 32'(delivered - d0), 32'd2);
`else
    check("a5_delivered", 32'(delivered - d0), 32'd1);
`endif

    // Backpressure holds the head byte.
    rxReady = 1'b0;
    tx = '{8'h01, 8'h02, 8'h03};
    frame(5);
    cyc(2);
    check("hold_valid", 32'(rxValid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("hold_data", 32'(rxData), 32'h01);
      cyc(3);
    end
    drain();
    check("seq_cnt", 32'(byteCnt), 32'(exp_cnt));

    // Overflow: DEPTH+2 bytes with no reader.
    do_reset();
    rxReady = 1'b0;
    tx.delete();
    for (int i = 0; i < DEPTH + 2; i++) tx.push_back(8'($urandom));
    frame(4);
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("ovf_set_abs", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(byteCnt), 32'(DEPTH));
    d0 = delivered;
    drain();
    check("ovf_drain", 32'(delivered - d0), 32'(DEPTH));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // spi_clk activity with CS high is ignored.
    do_reset();
    rxReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      spi_do = 1'($urandom);
      cyc(4);
      spi_clk = 1'b1;
      cyc(4);
      spi_clk = 1'b0;
    end
    cyc(10);
    check("idle_cnt", 32'(byteCnt), 32'd0);
    check("idle_valid", 32'(rxValid), 32'd0);

    // Full byte then a 5-bit tail.
    d0 = delivered;
    cs_start();
    send_bits(8'hFF, 8, 4);
    send_bits(8'($urandom), 5, 4);
    cs_end();
    drain();
    check("partial_cnt", 32'(byteCnt), 32'(exp_cnt));
`ifdef SPI_CAPTURE_FRAME_MARK_EN
    check("partial_delivered", 32'(delivered - d0), 32'd2);
`else
    check("partial_delivered", 32'(delivered - d0), 32'd1);
`endif

    // Reset in the middle of a byte.
    cs_start();
    send_bits(8'hB7, 4, 4);
    do_reset();
    d0 = delivered;
    tx = '{8'h3C};
    frame(4);
    drain();
`ifdef SPI_CAPTURE_FRAME_MARK_EN
    check("rstmid_cnt", 32'(byteCnt), 32'd2);
`else
    check("rstmid_cnt", 32'(byteCnt), 32'd1);
`endif
    check("rstmid_ovf", 32'(overflow), 32'd0);

    // Random frames, random spi rate and random backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      tx.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) tx.push_back(8'($urandom));
      half = int'($urandom_range(4, 6));
      frame(half);
    end
    rand_rdy = 1'b0;
    drain();
    check("rand_cnt", 32'(byteCnt), 32'(exp_cnt));
    check("rand_ovf", 32'(overflow), 32'(exp_ovf));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_capture.md
SPI_CAPTURE -- requirements
Module: spi_capture

Interface
REQ-001 Parameter: FIFO_DEPTH, default 16, captured-byte FIFO entries (power of 2, 4..256).
REQ-002 Ports: clk  input  1  system clock (166.67 MHz nominal).
REQ-003 Ports: rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 Ports: spi_clk  input  1  monitored SPI clock (mode 0, asynchronous to clk).
REQ-005 Ports: spi_cs  input  1  monitored chip select, active-low.
REQ-006 Ports: spi_do  input  1  monitored master-out data line.
REQ-007 Ports: rxData  output  8  head-of-FIFO captured byte.
REQ-008 Ports: rxValid  output  1  FIFO non-empty; rxData valid.
REQ-009 Ports: rxReady  input  1  downstream (UART formatter) accepts rxData.
REQ-010 Ports: byteCnt  output  8  count of bytes pushed to FIFO.
REQ-011 Ports: overflow  output  1  sticky, byte dropped on full FIFO.
REQ-012 Ports: busy  output  1  high while FSM in ACTIVE.

Function
REQ-013 spi_clk, spi_cs, spi_do SHALL each pass a 2-flop synchronizer; spi_do delayed to stay aligned with spi_clk edge detect.
REQ-014 Correct capture SHALL be required only for spi_clk period >= 8 clk periods.
REQ-015 FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synced spi_cs falling edge, ACTIVE->IDLE on synced spi_cs rising edge.
REQ-016 IDLE->ACTIVE SHALL clear 3-bit bit counter and shift register.
REQ-017 In ACTIVE, each synced spi_clk rising edge SHALL shift spi_do in, MSB first; spi_clk edges in IDLE ignored.
REQ-018 Eighth bit SHALL complete a byte: push to FIFO, bit counter wraps to 0, capture continues for next byte.
REQ-019 Partial byte (1..7 bits) at CS rising edge SHALL be discarded, no push.
REQ-020 Latency: 8th spi_clk pad rising edge to rxValid high SHALL be <= 4 clk cycles when FIFO empty.
REQ-021 FIFO first-word-fall-through: rxValid = not empty; pop on rxValid && rxReady; rxData stable while rxValid && !rxReady.
REQ-022 Push while full and no pop in same cycle: byte dropped, overflow set, byteCnt not incremented.
REQ-023 Push and pop same cycle while full: both performed, no overflow.
REQ-024 byteCnt SHALL increment by 1 per accepted push, wrap 255->0, not cleared by CS.
REQ-025 overflow SHALL clear only by reset.

Reset
REQ-026 Reset asserted SHALL immediately force: FSM IDLE, FIFO empty, rxValid 0, rxData 0x00, byteCnt 0, overflow 0, busy 0, synchronizers to idle (spi_cs 1, spi_clk 0).
REQ-027 Reset mid-frame SHALL discard partial byte and FIFO contents; after release, capture resumes only at next spi_cs falling edge.

Configuration
REQ-028 Macro SPI_CAPTURE_FRAME_MARK_EN defined: on CS rising edge ending a frame with >= 1 complete byte, push marker byte 0x0A (same full/overflow/byteCnt rules).
REQ-029 Macro undefined: no marker pushed; frame boundaries not visible on rxData.

Verification
REQ-030 Reset, CS low, send 0xA5 at spi_clk = clk/8, rxReady=1 -> one transfer rxData=0xA5 within 4 clk of 8th edge, byteCnt=1.
REQ-031 Frame 0x01,0x02,0x03 with rxReady=0 -> rxValid held, rxData=0x01 stable; raise rxReady -> 0x01,0x02,0x03 in order, byteCnt=3.
REQ-032 rxReady=0, send FIFO_DEPTH+2 bytes -> first 16 retained, overflow=1, byteCnt=16; drain yields exactly 16 bytes.
REQ-033 Send 0xFF then 5 bits, CS high -> only 0xFF delivered; with SPI_CAPTURE_FRAME_MARK_EN, 0xFF then 0x0A.
REQ-034 Assert rst after 4 bits of a byte, release, new frame 0x3C -> only 0x3C delivered, byteCnt=1, overflow=0.
